// File: rtl/idct_it_row.sv
// Iterative 8-point 1-D inverse DCT, one row at a time.
// A row of 8 coefficients is captured on the input handshake. Each output
// sample x[n] is built from 8 products T[n][k]*X[k] through one shared
// multiply-accumulator, then rounded, saturated and held until accepted.
module idct_it_row #(
  parameter int W_I   = 12,
  parameter int W_O   = 9,
  parameter int FRAC  = 12,
  parameter int W_ACC = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*W_I-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [W_O-1:0]     m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
);

  localparam int W_C = FRAC + 2;
  localparam int W_P = W_I + W_C;

  localparam logic signed [W_ACC-1:0] HALF = W_ACC'(2 ** (FRAC - 1));
  localparam logic signed [W_ACC-1:0] MAXV = W_ACC'(2 ** (W_O - 1) - 1);
  localparam logic signed [W_ACC-1:0] MINV = W_ACC'(-(2 ** (W_O - 1)));

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [W_I-1:0]   row [8];
  logic [2:0]              n;
  logic [2:0]              k;
  logic signed [W_ACC-1:0] acc;

  logic signed [W_C-1:0]   coef;
  logic signed [W_P-1:0]   prod;
  logic signed [W_ACC-1:0] sum;
  logic signed [W_ACC-1:0] rnd;
  logic signed [W_ACC-1:0] shifted;
  logic signed [W_O-1:0]   sat_res;

  // Cosine basis T[n][k] = round(2^12 * 0.5 * c(k) * cos((2n+1)k*pi/16)),
  // indexed by {n,k}. Values are for FRAC=12.
  function automatic int rom_val(input logic [5:0] idx);
    case (idx)
      6'o00: rom_val = 1448;  6'o01: rom_val = 2009;
      6'o02: rom_val = 1892;  6'o03: rom_val = 1703;
      6'o04: rom_val = 1448;  6'o05: rom_val = 1138;
      6'o06: rom_val = 784;   6'o07: rom_val = 400;
      6'o10: rom_val = 1448;  6'o11: rom_val = 1703;
      6'o12: rom_val = 784;   6'o13: rom_val = -400;
      6'o14: rom_val = -1448; 6'o15: rom_val = -2009;
      6'o16: rom_val = -1892; 6'o17: rom_val = -1138;
      6'o20: rom_val = 1448;  6'o21: rom_val = 1138;
      6'o22: rom_val = -784;  6'o23: rom_val = -2009;
      6'o24: rom_val = -1448; 6'o25: rom_val = 400;
      6'o26: rom_val = 1892;  6'o27: rom_val = 1703;
      6'o30: rom_val = 1448;  6'o31: rom_val = 400;
      6'o32: rom_val = -1892; 6'o33: rom_val = -1138;
      6'o34: rom_val = 1448;  6'o35: rom_val = 1703;
      6'o36: rom_val = -784;  6'o37: rom_val = -2009;
      6'o40: rom_val = 1448;  6'o41: rom_val = -400;
      6'o42: rom_val = -1892; 6'o43: rom_val = 1138;
      6'o44: rom_val = 1448;  6'o45: rom_val = -1703;
      6'o46: rom_val = -784;  6'o47: rom_val = 2009;
      6'o50: rom_val = 1448;  6'o51: rom_val = -1138;
      6'o52: rom_val = -784;  6'o53: rom_val = 2009;
      6'o54: rom_val = -1448; 6'o55: rom_val = -400;
      6'o56: rom_val = 1892;  6'o57: rom_val = -1703;
      6'o60: rom_val = 1448;  6'o61: rom_val = -1703;
      6'o62: rom_val = 784;   6'o63: rom_val = 400;
      6'o64: rom_val = -1448; 6'o65: rom_val = 2009;
      6'o66: rom_val = -1892; 6'o67: rom_val = 1138;
      6'o70: rom_val = 1448;  6'o71: rom_val = -2009;
      6'o72: rom_val = 1892;  6'o73: rom_val = -1703;
      6'o74: rom_val = 1448;  6'o75: rom_val = -1138;
      6'o76: rom_val = 784;   6'o77: rom_val = -400;
      default: rom_val = 0;
    endcase
  endfunction

  // Multiply-accumulate datapath and result rounding/saturation.
  always_comb begin
    coef    = W_C'(rom_val({n, k}));
    prod    = W_P'(row[k]) * W_P'(coef);
    sum     = acc + W_ACC'(prod);
    rnd     = sum + HALF;
    shifted = rnd >>> FRAC;
    if (shifted > MAXV) begin
      sat_res = MAXV[W_O-1:0];
    end else if (shifted < MINV) begin
      sat_res = MINV[W_O-1:0];
    end else begin
      sat_res = shifted[W_O-1:0];
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (s_valid) state_nxt = MAC;
      MAC:  if (k == 3'd7) state_nxt = OUT;
      OUT:  if (m_ready) state_nxt = (n == 3'd7) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Row capture, index counters, accumulator and output sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      n      <= '0;
      k      <= '0;
      acc    <= '0;
      m_data <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        row[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            for (int unsigned i = 0; i < 8; i++) begin
              row[i] <= s_data[i*W_I +: W_I];
            end
            n   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          k   <= k + 3'd1;
          if (k == 3'd7) begin
            m_data <= sat_res;
          end
        end
        OUT: begin
          if (m_ready && (n != 3'd7)) begin
            n   <= n + 3'd1;
            k   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready = (state == IDLE) && !rst;
  assign m_valid = (state == OUT);
  assign m_last  = (state == OUT) && (n == 3'd7);

endmodule

// File: tb/tb_idct_it_row.sv
// Self-checking bench for idct_it_row: directed rows, random rows against a
// floating-point cosine reference, backpressure, back-to-back and reset.
module tb_idct_it_row;

  localparam int W_I = 12;
  localparam int W_O = 9;
  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [8*W_I-1:0]   s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [W_O-1:0]     m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               m_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  idct_it_row #(.W_I(W_I), .W_O(W_O), .FRAC(12), .W_ACC(28)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: real-valued cosine basis rounded to integers, exact integer
  // sum, floor((sum + 2048) / 4096), clamp to the output range.
  task automatic model(input int x[8], output int y[8]);
    for (int n = 0; n < 8; n++) begin
      longint s;
      s = 0;
      for (int k = 0; k < 8; k++) begin
        real c;
        real t;
        int  ti;
        c  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        t  = 2048.0 * c * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        ti = $rtoi($floor(t + 0.5));
        s += longint'(ti) * longint'(x[k]);
      end
      y[n] = $rtoi($floor(real'(s + 2048) / 4096.0));
      if (y[n] > 255)  y[n] = 255;
      if (y[n] < -256) y[n] = -256;
    end
  endtask

  task automatic send_row(input int x[8], input string nm, output int acc_edge);
    int t;
    for (int k = 0; k < 8; k++) begin
      s_data[k*W_I +: W_I] = x[k][W_I-1:0];
    end
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 200) begin
      step();
      t++;
    end
    chk($sformatf("%s_accept", nm), int'(s_ready), 1);
    step();
    acc_edge = cyc;
    s_valid  = 1'b0;
  endtask

  task automatic recv_row(input int exp[8], input string nm, input int acc_edge,
                          input int nsamp, input int stall_i, output int last_edge);
    int prev;
    int edge_c;
    int hold_d;
    int hold_l;
    int t;
    prev      = acc_edge;
    last_edge = acc_edge;
    for (int i = 0; i < nsamp; i++) begin
      t = 0;
      while (!m_valid && t < 100) begin
        step();
        t++;
      end
      chk($sformatf("%s_valid%0d", nm, i), int'(m_valid), 1);
      if (!m_valid) return;
      chk($sformatf("%s_data%0d", nm, i), int'($signed(m_data)), exp[i]);
      chk($sformatf("%s_last%0d", nm, i), int'(m_last), (i == 7) ? 1 : 0);
      if (i == stall_i) begin
        hold_d  = int'($signed(m_data));
        hold_l  = int'(m_last);
        m_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          step();
          chk($sformatf("%s_stall_valid%0d", nm, j), int'(m_valid), 1);
          chk($sformatf("%s_stall_data%0d", nm, j), int'($signed(m_data)), hold_d);
          chk($sformatf("%s_stall_last%0d", nm, j), int'(m_last), hold_l);
          chk($sformatf("%s_stall_sready%0d", nm, j), int'(s_ready), 0);
        end
        m_ready = 1'b1;
      end
      step();
      edge_c = cyc;
      if (i != stall_i) begin
        chk($sformatf("%s_gap%0d", nm, i), edge_c - prev, 9);
      end
      prev      = edge_c;
      last_edge = edge_c;
    end
  endtask

  initial begin
    int r[8];
    int e[8];
    int rb[8];
    int eb[8];
    int acc_a;
    int acc_b;
    int last_a;
    int last_b;
    int quiet;

    // Reset state.
    step();
    step();
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_s_ready", int'(s_ready), 1);

    // DC only.
    r = '{64, 0, 0, 0, 0, 0, 0, 0};
    e = '{23, 23, 23, 23, 23, 23, 23, 23};
    send_row(r, "dc", acc_a);
    recv_row(e, "dc", acc_a, 8, -1, last_a);

    // Single first harmonic.
    r = '{0, 100, 0, 0, 0, 0, 0, 0};
    e = '{49, 42, 28, 10, -10, -28, -42, -49};
    send_row(r, "h1", acc_a);
    recv_row(e, "h1", acc_a, 8, -1, last_a);

    // Saturation both ways.
    r = '{2047, 0, 0, 0, 0, 0, 0, 0};
    e = '{255, 255, 255, 255, 255, 255, 255, 255};
    send_row(r, "satp", acc_a);
    recv_row(e, "satp", acc_a, 8, -1, last_a);
    r = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    e = '{-256, -256, -256, -256, -256, -256, -256, -256};
    send_row(r, "satn", acc_a);
    recv_row(e, "satn", acc_a, 8, -1, last_a);

    // Random rows: two small-magnitude, two full-range.
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 8; k++) begin
        if (q < 2) r[k] = int'($urandom_range(0, 600)) - 300;
        else       r[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      model(r, e);
      send_row(r, $sformatf("rnd%0d", q), acc_a);
      recv_row(e, $sformatf("rnd%0d", q), acc_a, 8, -1, last_a);
    end

    // Backpressure on sample 3.
    for (int k = 0; k < 8; k++) r[k] = int'($urandom_range(0, 400)) - 200;
    model(r, e);
    send_row(r, "bp", acc_a);
    recv_row(e, "bp", acc_a, 8, 3, last_a);

    // Back-to-back: row B waits with s_valid high while row A streams out.
    for (int k = 0; k < 8; k++) begin
      r[k]  = int'($urandom_range(0, 800)) - 400;
      rb[k] = int'($urandom_range(0, 800)) - 400;
    end
    model(r, e);
    model(rb, eb);
    send_row(r, "b2bA", acc_a);
    fork
      send_row(rb, "b2bB", acc_b);
      recv_row(e, "b2bA", acc_a, 8, -1, last_a);
    join
    chk("b2b_accept_edge", acc_b, last_a + 1);
    recv_row(eb, "b2bB", acc_b, 8, -1, last_b);

    // Reset mid-row after sample 2, then a fresh row.
    for (int k = 0; k < 8; k++) r[k] = int'($urandom_range(0, 600)) - 300;
    model(r, e);
    send_row(r, "mr", acc_a);
    recv_row(e, "mr", acc_a, 3, -1, last_a);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mr_valid_after_rst", int'(m_valid), 0);
    chk("mr_sready_after_rst", int'(s_ready), 1);
    quiet = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (m_valid) quiet++;
    end
    chk("mr_no_valid_idle", quiet, 0);
    for (int k = 0; k < 8; k++) r[k] = int'($urandom_range(0, 600)) - 300;
    model(r, e);
    send_row(r, "mr2", acc_a);
    recv_row(e, "mr2", acc_a, 8, -1, last_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
